// File: rtl/cu_fetch_core_pkg.sv
// Shared widths, opcode constants and return-stack entry layout for the
// control-unit fetch/sequencing datapath.
package cu_fetch_core_pkg;

  localparam int IR_W        = 16;
  localparam int PC_W        = 9;
  localparam int FLAGS_W     = 4;
  localparam int STACK_DEPTH = 8;
  localparam int SP_W        = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W       = $clog2(STACK_DEPTH);

  localparam logic [4:0] RET_OPCODE  = 5'b10101;
  localparam logic [4:0] CALL_OPCODE = 5'b10100;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [FLAGS_W-1:0] flags;
  } stack_entry_t;

  function automatic logic is_ret(input logic [IR_W-1:0] ir);
    return ir[15:11] == RET_OPCODE;
  endfunction

  function automatic logic [PC_W-1:0] jump_imm(input logic [IR_W-1:0] ir);
    return ir[10:2];
  endfunction

endpackage

// File: rtl/cu_return_stack.sv
// Return stack of {pc, flags}: registered array plus an entry count.
// The top entry is shown combinationally so a pop cycle can consume it.
module cu_return_stack
  import cu_fetch_core_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [FLAGS_W-1:0] push_flags,
  output logic [PC_W-1:0]    top_pc,
  output logic [FLAGS_W-1:0] top_flags,
  output logic               empty,
  output logic               full
);

  stack_entry_t     mem_q [STACK_DEPTH];
  stack_entry_t     mem_d [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d, sp_m1;
  logic [IDX_W-1:0] top_idx, wr_idx;
  stack_entry_t     push_entry, top_entry;

  assign empty      = (sp_q == '0);
  assign full       = (sp_q == SP_W'(STACK_DEPTH));
  assign sp_m1      = sp_q - 1'b1;
  assign top_idx    = sp_m1[IDX_W-1:0];
  assign wr_idx     = sp_q[IDX_W-1:0];
  assign push_entry = '{pc: push_pc, flags: push_flags};
  assign top_entry  = empty ? '0 : mem_q[top_idx];
  assign top_pc     = top_entry.pc;
  assign top_flags  = top_entry.flags;

  // Push+pop on a non-empty stack replaces the top in place; on an empty
  // stack it falls through to a plain push.
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && pop && !empty) begin
      mem_d[top_idx] = push_entry;
    end else if (push && !full) begin
      mem_d[wr_idx] = push_entry;
      sp_d          = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/cu_fetch_core.sv
// Control-unit fetch datapath: IR, PC with internal load-source mux, and the
// return stack. Strobes come straight from the microcode sequencer.
module cu_fetch_core
  import cu_fetch_core_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ir_load,
  input  logic [IR_W-1:0]    ir_in,
  input  logic               pc_load,
  input  logic               pc_inc,
  input  logic               pc_en_out,
  input  logic               stack_push,
  input  logic               stack_pop,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic [IR_W-1:0]    ir_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_bus,
  output logic [PC_W-1:0]    stack_pc,
  output logic [FLAGS_W-1:0] stack_flags,
  output logic               stack_empty,
  output logic               stack_full
);

  logic [IR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_src;

  cu_return_stack u_stack (
    .clk        (clk),
    .rst        (rst),
    .push       (stack_push),
    .pop        (stack_pop),
    .push_pc    (pc_q),
    .push_flags (flags_in),
    .top_pc     (stack_pc),
    .top_flags  (stack_flags),
    .empty      (stack_empty),
    .full       (stack_full)
  );

  // RET takes the pre-pop top of stack, so a same-cycle pop is safe.
  assign pc_src = is_ret(ir_q) ? stack_pc : jump_imm(ir_q);

  always_comb begin
    ir_d = ir_load ? ir_in : ir_q;
    pc_d = pc_q;
    if (pc_load)     pc_d = pc_src;
    else if (pc_inc) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= '0;
      pc_q <= '0;
    end else begin
      ir_q <= ir_d;
      pc_q <= pc_d;
    end
  end

  assign ir_out = ir_q;
  assign pc_out = pc_q;
  assign pc_bus = pc_en_out ? pc_q : '0;

endmodule

// File: tb/tb_cu_fetch_core.sv
// Bench for cu_fetch_core: directed scenarios with literal expectations, then
// randomized strobes checked every cycle against a queue-based model.
module tb_cu_fetch_core;

  logic        clk = 1'b0;
  logic        rst, ir_load, pc_load, pc_inc, pc_en_out, stack_push, stack_pop;
  logic [15:0] ir_in;
  logic [3:0]  flags_in;
  logic [15:0] ir_out;
  logic [8:0]  pc_out, pc_bus, stack_pc;
  logic [3:0]  stack_flags;
  logic        stack_empty, stack_full;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [15:0] m_ir;
  logic [8:0]  m_pc;
  logic [12:0] m_stk[$];

  cu_fetch_core dut (
    .clk         (clk),
    .rst         (rst),
    .ir_load     (ir_load),
    .ir_in       (ir_in),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .pc_en_out   (pc_en_out),
    .stack_push  (stack_push),
    .stack_pop   (stack_pop),
    .flags_in    (flags_in),
    .ir_out      (ir_out),
    .pc_out      (pc_out),
    .pc_bus      (pc_bus),
    .stack_pc    (stack_pc),
    .stack_flags (stack_flags),
    .stack_empty (stack_empty),
    .stack_full  (stack_full)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] m_top();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 13'd0;
  endfunction

  // Model: a queue is the stack, back of the queue is the top.
  task automatic model_update();
    logic [12:0] top;
    logic [8:0]  src;
    int          n;
    if (rst) begin
      m_ir = '0;
      m_pc = '0;
      m_stk.delete();
    end else begin
      top = m_top();
      src = (m_ir[15:11] == 5'b10101) ? top[12:4] : m_ir[10:2];
      n   = m_stk.size();
      if (stack_push && stack_pop && n > 0) m_stk[n-1] = {m_pc, flags_in};
      else if (stack_push && n < 8)         m_stk.push_back({m_pc, flags_in});
      else if (stack_pop && n > 0)          void'(m_stk.pop_back());
      if (pc_load)     m_pc = src;
      else if (pc_inc) m_pc = m_pc + 9'd1;
      if (ir_load) m_ir = ir_in;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; ir_load = 0; pc_load = 0; pc_inc = 0; pc_en_out = 0;
    stack_push = 0; stack_pop = 0; ir_in = '0; flags_in = '0;
  endtask

  task automatic cyc(input bit ld_ir, input logic [15:0] ir, input bit ld_pc, input bit inc,
                     input bit push, input bit pop, input logic [3:0] flg);
    ir_load = ld_ir; ir_in = ir; pc_load = ld_pc; pc_inc = inc;
    stack_push = push; stack_pop = pop; flags_in = flg;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    idle();
  endtask

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin : compare
    logic [12:0] t;
    if (cmp_en) begin
      t = m_top();
      chk("ir_out", ir_out, m_ir);
      chk("pc_out", pc_out, m_pc);
      chk("pc_bus", pc_bus, pc_en_out ? m_pc : 9'd0);
      chk("stack_pc", stack_pc, t[12:4]);
      chk("stack_flags", stack_flags, t[3:0]);
      chk("stack_empty", stack_empty, m_stk.size() == 0);
      chk("stack_full", stack_full, m_stk.size() == 8);
    end
  end

  initial begin
    idle();
    // reset wins over every strobe
    rst = 1; ir_load = 1; ir_in = 16'hFFFF; pc_load = 1; pc_inc = 1;
    pc_en_out = 1; stack_push = 1; stack_pop = 0; flags_in = 4'hF;
    tick();
    tick();
    cmp_en = 1'b1;
    chk("rst_ir", ir_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_empty", stack_empty, 1);
    chk("rst_bus", pc_bus, 0);
    chk("rst_full", stack_full, 0);
    idle();

    // fetch / jump
    cyc(1, 16'h8028, 0, 0, 0, 0, 0);
    chk("ir_capture", ir_out, 16'h8028);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("jump_imm", pc_out, 10);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);
    chk("inc3", pc_out, 13);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("load_over_inc", pc_out, 10);

    // wrap and bus
    cyc(1, 16'h07FC, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("pc_max", pc_out, 511);
    pc_en_out = 1; #1;
    chk("bus_on", pc_bus, 511);
    pc_en_out = 0; #1;
    chk("bus_off", pc_bus, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("wrap", pc_out, 0);

    // call / return
    do_reset();
    cyc(1, 16'h0014, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4'hA);
    chk("call_pc", stack_pc, 5);
    chk("call_flags", stack_flags, 4'hA);
    cyc(1, 16'h0050, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("pc20", pc_out, 20);
    cyc(1, 16'hA800, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("ret_pc", pc_out, 5);
    chk("ret_empty", stack_empty, 1);

    // full / empty
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 4'(i));
    end
    chk("full", stack_full, 1);
    chk("full_top", stack_pc, 8);
    chk("full_flags", stack_flags, 8);
    for (int k = 0; k < 9; k++) begin
      chk("pop_top", stack_pc, (k < 8) ? 8 - k : 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
    end
    chk("drained_empty", stack_empty, 1);
    chk("drained_pc", stack_pc, 0);
    chk("drained_flags", stack_flags, 0);

    // push+pop replaces top
    do_reset();
    cyc(1, 16'h000C, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4'h3);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4'h4);
    chk("pp_before", stack_pc, 4);
    cyc(1, 16'h001C, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 4'h7);
    chk("pp_top", stack_pc, 7);
    chk("pp_flags", stack_flags, 7);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("pp_after_pop", stack_pc, 3);
    chk("pp_not_empty", stack_empty, 0);

    // randomized phases alternating push-heavy and pop-heavy
    for (int p = 0; p < 12; p++) begin
      repeat (250) begin
        rst        = ($urandom_range(0, 99) == 0);
        ir_load    = ($urandom_range(0, 3) == 0);
        ir_in      = {(($urandom_range(0, 2) == 0) ? 5'b10101 : 5'($urandom_range(0, 31))),
                      11'($urandom)};
        pc_load    = ($urandom_range(0, 3) == 0);
        pc_inc     = ($urandom_range(0, 1) == 1);
        pc_en_out  = ($urandom_range(0, 1) == 1);
        stack_push = (p % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
        stack_pop  = (p % 2 == 1) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
        flags_in   = 4'($urandom);
        tick();
      end
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
